// File: rtl/xoodyak_hash_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_pkg
// Brief    : Shared constants, FSM encoding and byte-select helper for the
//            streaming Xoodyak hash controller.
// Revision : 1.0 - initial release
// ============================================================================
package xoodyak_pkg;

    localparam int STATE_W     = 384;
    localparam int STATE_BYTES = 48;
    localparam int FILL_W      = 6;

    localparam logic [7:0] PAD_BYTE   = 8'h01;
    localparam logic [7:0] CD_FIRST   = 8'h01;
    localparam logic [7:0] CU_SQUEEZE = 8'h40;
    localparam logic [7:0] CU_NONE    = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ABSORB    = 3'd1,
        S_DOWN      = 3'd2,
        S_UP        = 3'd3,
        S_WAIT_PERM = 3'd4,
        S_SQUEEZE   = 3'd5
    } fsm_state_t;

    function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] s,
                                            input logic [FILL_W-1:0]  idx);
        get_byte = 8'h00;
        for (int i = 0; i < STATE_BYTES; i++) begin
            if (FILL_W'(i) == idx) get_byte = s[8*i +: 8];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/xoodyak_hash_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_hash_stream_if
// Brief    : Message, permutation and digest handshakes of the hash stream.
// Revision : 1.0 - initial release
// ============================================================================
interface xoodyak_hash_stream_if #(
    parameter int LEN_W = 16
);
    import xoodyak_pkg::*;

    logic               start;
    logic [LEN_W-1:0]   msg_len;
    logic [7:0]         out_len;
    logic [7:0]         msg_data;
    logic               msg_valid;
    logic               msg_ready;
    logic               perm_start;
    logic [STATE_W-1:0] perm_state_out;
    logic [STATE_W-1:0] perm_state_in;
    logic               perm_done;
    logic [7:0]         hash_data;
    logic               hash_valid;
    logic               hash_ready;
    logic               busy;
    logic               done;

    // master: message source, Xoodoo core and digest sink side
    modport master (
        output start, msg_len, out_len, msg_data, msg_valid,
               perm_state_in, perm_done, hash_ready,
        input  msg_ready, perm_start, perm_state_out,
               hash_data, hash_valid, busy, done
    );

    modport slave (
        input  start, msg_len, out_len, msg_data, msg_valid,
               perm_state_in, perm_done, hash_ready,
        output msg_ready, perm_start, perm_state_out,
               hash_data, hash_valid, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/xoodyak_hash_stream_rate_buffer.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_rate_buffer
// Brief    : Collects up to RATE_BYTES message bytes of one absorb block.
// Revision : 1.0 - initial release
// ============================================================================
module xoodyak_rate_buffer
    import xoodyak_pkg::*;
#(
    parameter int RATE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_enable,
    input  logic [FILL_W-1:0]       i_target,
    input  logic [7:0]              i_msg_data,
    input  logic                    i_msg_valid,
    output logic                    o_msg_ready,
    output logic [FILL_W-1:0]       o_fill,
    output logic                    o_full,
    output logic [RATE_BYTES*8-1:0] o_block
);

    logic [FILL_W-1:0]       r_fill;
    logic [RATE_BYTES*8-1:0] r_block;
    logic                    w_xfer;

    assign o_msg_ready = i_enable && (r_fill < i_target);
    assign w_xfer      = o_msg_ready && i_msg_valid;
    // Full also when the byte completing the block is transferring now,
    // so the controller leaves ABSORB on the same edge.
    assign o_full      = (r_fill == i_target) ||
                         (w_xfer && ((r_fill + FILL_W'(1)) == i_target));
    assign o_fill      = r_fill;
    assign o_block     = r_block;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_fill <= '0;
        end else if (w_xfer) begin
            r_fill <= r_fill + FILL_W'(1);
        end
    end

    for (genvar i = 0; i < RATE_BYTES; i++) begin : g_byte
        always_ff @(posedge clk) begin
            if (reset) begin
                r_block[8*i +: 8] <= 8'h00;
            end else if (w_xfer && (r_fill == FILL_W'(i))) begin
                r_block[8*i +: 8] <= i_msg_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xoodyak_hash_stream.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_hash_stream
// Brief    : Streaming Xoodyak hash controller around an external Xoodoo core.
// Revision : 1.0 - initial release
// ============================================================================
module xoodyak_hash_stream
    import xoodyak_pkg::*;
#(
    parameter int RATE_BYTES = 16,
    parameter int HASH_BYTES = 32,
    parameter int LEN_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    xoodyak_hash_stream_if.slave bus
);

    fsm_state_t              r_fsm;
    fsm_state_t              w_fsm_next;
    logic [STATE_W-1:0]      r_state;
    logic [STATE_W-1:0]      r_perm_out;
    logic [STATE_W-1:0]      w_down_state;
    logic [7:0]              r_cd;
    logic [7:0]              r_olen;
    logic [7:0]              w_cu_next;
    logic [LEN_W-1:0]        r_rem;
    logic [LEN_W-1:0]        w_rem_after;
    logic [FILL_W-1:0]       r_sq_idx;
    logic [FILL_W-1:0]       w_fill;
    logic [FILL_W-1:0]       w_target;
    logic                    r_squeeze_phase;
    logic                    r_done;
    logic                    w_full;
    logic                    w_msg_ready;
    logic                    w_hash_xfer;
    logic [RATE_BYTES*8-1:0] w_block;
    logic                    w_perm_start;
    logic                    w_hash_valid;
    logic                    w_busy;
    logic [7:0]              w_hash_data;

    assign w_target = (r_rem < LEN_W'(RATE_BYTES)) ? r_rem[FILL_W-1:0]
                                                   : FILL_W'(RATE_BYTES);

    xoodyak_rate_buffer #(
        .RATE_BYTES (RATE_BYTES)
    ) u_rate_buffer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (r_fsm == S_DOWN),
        .i_enable    (r_fsm == S_ABSORB),
        .i_target    (w_target),
        .i_msg_data  (bus.msg_data),
        .i_msg_valid (bus.msg_valid),
        .o_msg_ready (w_msg_ready),
        .o_fill      (w_fill),
        .o_full      (w_full),
        .o_block     (w_block)
    );

    // Down: xor the collected block, pad right after it, then the domain byte.
    // In the squeeze phase the buffer is empty so only byte 0 gets the pad.
    always_comb begin
        w_down_state = r_state;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (FILL_W'(i) < w_fill) w_down_state[8*i +: 8] ^= w_block[8*i +: 8];
        end
        for (int i = 0; i < STATE_BYTES; i++) begin
            if (FILL_W'(i) == w_fill) w_down_state[8*i +: 8] ^= PAD_BYTE;
        end
        w_down_state[STATE_W-1 -: 8] ^= r_cd;
    end

    assign w_rem_after = r_rem - LEN_W'(w_fill);
    assign w_cu_next   = (!r_squeeze_phase && (w_rem_after == '0)) ? CU_SQUEEZE : CU_NONE;
    assign w_hash_xfer = (r_fsm == S_SQUEEZE) && bus.hash_ready;

    always_ff @(posedge clk) begin
        if (reset) r_fsm <= S_IDLE;
        else       r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE:      if (bus.start) w_fsm_next = S_ABSORB;
            S_ABSORB:    if (w_full) w_fsm_next = S_DOWN;
            S_DOWN:      w_fsm_next = S_UP;
            S_UP:        w_fsm_next = S_WAIT_PERM;
            S_WAIT_PERM: begin
                if (bus.perm_done) begin
                    w_fsm_next = (!r_squeeze_phase && (r_rem != '0)) ? S_ABSORB : S_SQUEEZE;
                end
            end
            S_SQUEEZE: begin
                if (w_hash_xfer) begin
                    if (r_olen == 8'd1)                             w_fsm_next = S_IDLE;
                    else if (r_sq_idx == FILL_W'(RATE_BYTES - 1))   w_fsm_next = S_DOWN;
                end
            end
            default:     w_fsm_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_perm_start = (r_fsm == S_UP);
        w_hash_valid = (r_fsm == S_SQUEEZE);
        w_busy       = (r_fsm != S_IDLE);
        w_hash_data  = w_hash_valid ? get_byte(r_state, r_sq_idx) : 8'h00;
    end

    assign bus.msg_ready      = w_msg_ready;
    assign bus.perm_start     = w_perm_start;
    assign bus.perm_state_out = r_perm_out;
    assign bus.hash_valid     = w_hash_valid;
    assign bus.hash_data      = w_hash_data;
    assign bus.busy           = w_busy;
    assign bus.done           = r_done;

    // The Up xor is folded in when Down completes so that perm_state_out
    // is already final in the cycle perm_start is raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= '0;
            r_perm_out      <= '0;
            r_cd            <= 8'h00;
            r_olen          <= 8'h00;
            r_rem           <= '0;
            r_sq_idx        <= '0;
            r_squeeze_phase <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state         <= '0;
                        r_cd            <= CD_FIRST;
                        r_rem           <= bus.msg_len;
                        r_olen          <= (bus.out_len == 8'd0) ? 8'(HASH_BYTES) : bus.out_len;
                        r_squeeze_phase <= 1'b0;
                    end
                end
                S_DOWN: begin
                    r_state    <= w_down_state;
                    r_perm_out <= w_down_state ^ {w_cu_next, {(STATE_W-8){1'b0}}};
                    r_cd       <= CU_NONE;
                    r_rem      <= w_rem_after;
                end
                S_UP: begin
                    r_state <= r_perm_out;
                end
                S_WAIT_PERM: begin
                    if (bus.perm_done) begin
                        r_state  <= bus.perm_state_in;
                        r_sq_idx <= '0;
                        if (r_rem == '0) r_squeeze_phase <= 1'b1;
                    end
                end
                S_SQUEEZE: begin
                    if (w_hash_xfer && (r_olen != 8'd0)) begin
                        r_olen   <= r_olen - 8'd1;
                        r_sq_idx <= r_sq_idx + FILL_W'(1);
                        if (r_olen == 8'd1) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xoodyak_hash_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_xoodyak_hash_stream
// Brief    : Scoreboard bench with identity Xoodoo stub and Cyclist-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xoodyak_hash_stream;
    import xoodyak_pkg::*;

    localparam int RATE = 16;
    localparam int HB   = 32;
    localparam int LW   = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xoodyak_hash_stream_if #(.LEN_W(LW)) bus ();

    xoodyak_hash_stream #(
        .RATE_BYTES (RATE),
        .HASH_BYTES (HB),
        .LEN_W      (LW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [STATE_W-1:0] exp_perm[$];
    logic [7:0]         exp_hash[$];
    int checks   = 0;
    int failures = 0;

    bit req_reset_chk = 0, req_end = 0, req_clr = 0, req_timeout = 0;
    bit req_ready_chk = 0, no_hash = 0;
    int exp_perm_cnt = 0;

    // ---------------- reference model: Cyclist hash with identity permutation
    function automatic logic [STATE_W-1:0] pack_state(input logic [7:0] st[STATE_BYTES]);
        logic [STATE_W-1:0] v;
        for (int i = 0; i < STATE_BYTES; i++) v[8*i +: 8] = st[i];
        return v;
    endfunction

    task automatic model_run(input logic [7:0] msg[$], input int olen, output int nperm);
        logic [7:0] st[STATE_BYTES];
        int len, nblk, n, left, k;
        bit first;
        len = msg.size();
        for (int i = 0; i < STATE_BYTES; i++) st[i] = 8'h00;
        nperm = 0;
        nblk  = (len == 0) ? 1 : (len + RATE - 1) / RATE;
        for (int b = 0; b < nblk; b++) begin
            n = len - b * RATE;
            if (n > RATE) n = RATE;
            for (int j = 0; j < n; j++) st[j] ^= msg[b*RATE + j];
            st[n] ^= 8'h01;
            if (b == 0)        st[47] ^= 8'h01;
            if (b == nblk - 1) st[47] ^= 8'h40;
            exp_perm.push_back(pack_state(st));
            nperm++;
        end
        left  = olen;
        first = 1'b1;
        while (left > 0) begin
            if (!first) begin
                st[0] ^= 8'h01;
                exp_perm.push_back(pack_state(st));
                nperm++;
            end
            k = (left < RATE) ? left : RATE;
            for (int j = 0; j < k; j++) exp_hash.push_back(st[j]);
            left -= k;
            first = 1'b0;
        end
    endtask

    // ---------------- identity Xoodoo stub (deliberately ignores reset)
    logic [STATE_W-1:0] stub_held;
    int stub_cnt = 0;
    bit stub_seen;
    initial begin
        bus.perm_done     = 1'b0;
        bus.perm_state_in = '0;
        forever begin
            @(negedge clk);
            stub_seen = bus.perm_start;
            if (stub_seen) stub_held = bus.perm_state_out;
            @(posedge clk);
            #1;
            bus.perm_done = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    bus.perm_done     = 1'b1;
                    bus.perm_state_in = stub_held;
                end
            end
            if (stub_seen) stub_cnt = 3;
        end
    end

    // ---------------- digest sink: 0 always ready, 1 random, 2 stall on byte 2
    int ready_mode = 0;
    int rd_nx = 0, rd_hold = 0;
    bit rd_x;
    initial begin
        bus.hash_ready = 1'b1;
        forever begin
            @(negedge clk);
            rd_x = bus.hash_valid && bus.hash_ready;
            @(posedge clk);
            #1;
            if (ready_mode != 2) begin
                rd_nx   = 0;
                rd_hold = 0;
            end else if (rd_x) begin
                rd_nx++;
            end
            case (ready_mode)
                0: bus.hash_ready = 1'b1;
                1: bus.hash_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (rd_nx == 1 && rd_hold < 4) begin
                        bus.hash_ready = 1'b0;
                        rd_hold++;
                    end else begin
                        bus.hash_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- monitor / scoreboard (sole owner of the counters)
    int perm_cnt = 0, done_cnt = 0;
    bit prev_hold = 0;
    logic [7:0] prev_data;
    logic [STATE_W-1:0] e_perm;
    logic [7:0] e_hash;

    task automatic chk(input bit ok, input string name, input string act, input string exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (req_reset_chk) begin
            chk(bus.msg_ready == 1'b0, "rst_msg_ready", $sformatf("%0b", bus.msg_ready), "0");
            chk(bus.perm_start == 1'b0, "rst_perm_start", $sformatf("%0b", bus.perm_start), "0");
            chk(bus.perm_state_out == '0, "rst_perm_state_out", $sformatf("%0h", bus.perm_state_out), "0");
            chk(bus.hash_valid == 1'b0, "rst_hash_valid", $sformatf("%0b", bus.hash_valid), "0");
            chk(bus.hash_data == 8'h00, "rst_hash_data", $sformatf("%0h", bus.hash_data), "0");
            chk(bus.busy == 1'b0, "rst_busy", $sformatf("%0b", bus.busy), "0");
            chk(bus.done == 1'b0, "rst_done", $sformatf("%0b", bus.done), "0");
        end
        if (req_ready_chk)
            chk(bus.msg_ready == 1'b1, "start_to_msg_ready", $sformatf("%0b", bus.msg_ready), "1");
        if (req_timeout)
            chk(1'b0, "timeout", "expired", "event within bound");
        if (bus.perm_start) begin
            perm_cnt++;
            if (exp_perm.size() == 0) begin
                chk(1'b0, "perm_unexpected", $sformatf("%0h", bus.perm_state_out), "none");
            end else begin
                e_perm = exp_perm.pop_front();
                chk(bus.perm_state_out == e_perm, "perm_state",
                    $sformatf("%0h", bus.perm_state_out), $sformatf("%0h", e_perm));
            end
        end
        if (no_hash && bus.hash_valid)
            chk(1'b0, "hash_after_reset", "hash_valid=1", "hash_valid=0");
        if (prev_hold)
            chk(bus.hash_valid && bus.hash_data == prev_data, "hash_hold",
                $sformatf("v=%0b d=%0h", bus.hash_valid, bus.hash_data),
                $sformatf("v=1 d=%0h", prev_data));
        if (bus.hash_valid && bus.hash_ready) begin
            if (exp_hash.size() == 0) begin
                chk(1'b0, "hash_unexpected", $sformatf("%0h", bus.hash_data), "none");
            end else begin
                e_hash = exp_hash.pop_front();
                chk(bus.hash_data == e_hash, "hash_byte",
                    $sformatf("%0h", bus.hash_data), $sformatf("%0h", e_hash));
            end
        end
        prev_hold = bus.hash_valid && !bus.hash_ready && !reset;
        prev_data = bus.hash_data;
        if (bus.done) done_cnt++;
        if (req_end) begin
            chk(perm_cnt == exp_perm_cnt, "perm_count", $sformatf("%0d", perm_cnt),
                $sformatf("%0d", exp_perm_cnt));
            chk(done_cnt == 1, "done_count", $sformatf("%0d", done_cnt), "1");
            chk(exp_hash.size() == 0 && exp_perm.size() == 0, "scoreboard_drained",
                $sformatf("hash=%0d perm=%0d", exp_hash.size(), exp_perm.size()), "hash=0 perm=0");
        end
        if (req_end || req_clr) begin
            perm_cnt = 0;
            done_cnt = 0;
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_timeout();
        req_timeout = 1'b1;
        tick();
        req_timeout = 1'b0;
    endtask

    task automatic do_run(input logic [7:0] msg[$], input int olen_in, input int mode,
                          input bit rnd_valid, input bit poke);
        int nperm, olen_eff, wc;
        bit ok;
        olen_eff = (olen_in == 0) ? HB : olen_in;
        model_run(msg, olen_eff, nperm);
        ready_mode  = mode;
        bus.start   = 1'b1;
        bus.msg_len = LW'(msg.size());
        bus.out_len = 8'(olen_in);
        tick();
        bus.start = 1'b0;
        if (msg.size() > 0) begin
            req_ready_chk = 1'b1;
            tick();
            req_ready_chk = 1'b0;
        end
        for (int i = 0; i < msg.size(); i++) begin
            if (rnd_valid) repeat ($urandom_range(0, 2)) tick();
            bus.msg_valid = 1'b1;
            bus.msg_data  = msg[i];
            wc = 0;
            do begin
                @(negedge clk);
                ok = bus.msg_ready;
                tick();
                wc++;
            end while (!ok && wc < 200);
            bus.msg_valid = 1'b0;
            bus.msg_data  = 8'($urandom);
            if (!ok) begin
                pulse_timeout();
                break;
            end
            if (poke && i == 0) begin
                bus.start   = 1'b1;
                bus.msg_len = LW'(msg.size() + 7);
                bus.out_len = 8'(olen_in + 3);
                tick();
                bus.start = 1'b0;
            end
        end
        wc = 0;
        ok = 1'b0;
        while (!ok && wc < 3000) begin
            @(negedge clk);
            ok = bus.done;
            tick();
            wc++;
        end
        if (!ok) pulse_timeout();
        exp_perm_cnt = nperm;
        req_end = 1'b1;
        tick();
        req_end    = 1'b0;
        ready_mode = 0;
    endtask

    logic [7:0] m[$];
    int nperm_abort, wc;
    bit seen;

    initial begin
        bus.start     = 1'b0;
        bus.msg_len   = '0;
        bus.out_len   = 8'h00;
        bus.msg_data  = 8'h00;
        bus.msg_valid = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        req_reset_chk = 1'b1;
        tick();
        req_reset_chk = 1'b0;

        m.delete();
        do_run(m, 0, 0, 0, 0);

        m.delete();
        for (int i = 0; i < 16; i++) m.push_back(8'(i));
        do_run(m, 0, 0, 0, 0);

        m.delete();
        for (int i = 0; i < 17; i++) m.push_back(8'(i));
        do_run(m, 0, 0, 0, 0);

        m.delete();
        for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
        do_run(m, 5, 2, 0, 0);

        m.delete();
        for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
        do_run(m, 0, 0, 1, 1);

        // reset while the permutation is outstanding; its done arrives later
        m.delete();
        model_run(m, HB, nperm_abort);
        bus.start   = 1'b1;
        bus.msg_len = '0;
        bus.out_len = 8'h00;
        tick();
        bus.start = 1'b0;
        seen = 1'b0;
        wc   = 0;
        while (!seen && wc < 50) begin
            @(negedge clk);
            seen = bus.perm_start;
            tick();
            wc++;
        end
        if (!seen) pulse_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hash.delete();
        exp_perm.delete();
        no_hash = 1'b1;
        repeat (8) tick();
        req_reset_chk = 1'b1;
        tick();
        req_reset_chk = 1'b0;
        no_hash = 1'b0;
        req_clr = 1'b1;
        tick();
        req_clr = 1'b0;

        for (int r = 0; r < 25; r++) begin
            m.delete();
            for (int i = 0; i < $urandom_range(0, 50); i++) m.push_back(8'($urandom));
            do_run(m, $urandom_range(0, 40), 1, 1, 0);
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/xoodyak_hash_stream.md
# xoodyak_hash_stream

Parametrised, streaming successor to the Xoodyak hash controller: absorbs a byte stream of known length into the 384-bit Xoodyak state, calls an external Xoodoo permutation through a start/done handshake and squeezes a runtime-selectable number of digest bytes under backpressure. No whole-message buffer; one rate block is collected at a time. Sits between the message source and the Xoodoo core.

## Interface
- RATE_BYTES, 16, absorb/squeeze rate in bytes (1..47)
- HASH_BYTES, 32, digest length used when out_len = 0
- LEN_W, 16, width of msg_len
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears everything
- start  in  1  one-cycle request; accepted only in IDLE
- msg_len  in  LEN_W  message byte count, latched on accepted start
- out_len  in  8  digest bytes, latched on start; 0 selects HASH_BYTES
- msg_data  in  8  message byte
- msg_valid / msg_ready  in / out  1  byte handshake; transfer when both high
- perm_start  out  1  one-cycle pulse launching Xoodoo
- perm_state_out  out  384  state presented to Xoodoo, stable from perm_start until perm_done
- perm_state_in  in  384  permuted state, sampled on perm_done
- perm_done  in  1  one-cycle completion pulse
- hash_data / hash_valid / hash_ready  out / out / in  8/1/1  digest byte handshake
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after last digest byte transfers

## Operation
- State byte i = state[8i+7:8i]; last byte = state[383:376].
- FSM: IDLE, ABSORB, DOWN, UP, WAIT_PERM, SQUEEZE.
- IDLE: start -> clear state to 0, cd = 0x01, rem = msg_len, olen = out_len or HASH_BYTES, -> ABSORB.
- ABSORB: target = min(rem, RATE_BYTES); msg_ready high while fill < target; byte k written to block byte k. fill == target (immediately if rem = 0) -> DOWN.
- DOWN (1 cycle): state bytes 0..fill-1 ^= block; state byte fill ^= 0x01 (always, including full block); last byte ^= cd; cd <= 0x00; rem -= fill; fill <= 0. -> UP with cu = 0x40 if rem becomes 0 in absorb phase, else cu = 0x00.
- UP (1 cycle): last byte ^= cu; perm_state_out <= state; perm_start = 1; -> WAIT_PERM.
- WAIT_PERM: on perm_done, state <= perm_state_in; -> ABSORB if rem > 0 in absorb phase, else SQUEEZE.
- SQUEEZE: emits state bytes 0..min(olen, RATE_BYTES)-1 in order; olen decrements per transfer. olen reaches 0 -> done pulse, -> IDLE. Block exhausted with olen > 0 -> squeeze-DOWN (empty block: byte 0 ^= 0x01, cd = 0x00) -> UP cu = 0x00 -> WAIT_PERM -> SQUEEZE.
- Empty message performs exactly one Down with empty block.

## Timing
- Reset values: msg_ready 0, perm_start 0, perm_state_out 0, hash_valid 0, hash_data 0, busy 0, done 0; FSM IDLE.
- start to msg_ready high: 1 cycle. Last absorb byte to perm_start: 2 cycles (DOWN, UP).
- perm_done to hash_valid: 1 cycle; back-to-back digest bytes at 1/cycle with hash_ready high.
- hash_valid/hash_data held stable while hash_ready low.
- start while busy ignored; perm_done outside WAIT_PERM ignored; msg_valid outside ABSORB ignored.
- reset mid-operation (any state, incl. WAIT_PERM) -> IDLE next cycle; a later stray perm_done has no effect.
- rem/olen never underflow; widths LEN_W and 8.

## Structure
- Package xoodyak_pkg: STATE_W = 384, FSM state enum, PAD_BYTE = 8'h01, CD_FIRST = 8'h01, CU_SQUEEZE = 8'h40, CU_NONE = 8'h00.
- Sub-module xoodyak_rate_buffer: RATE_BYTES byte collector with fill counter and msg handshake.

## Test plan (identity-permutation stub: perm_done 3 cycles after perm_start, returns input)
- msg_len 0, out_len 0 -> one absorb perm_start with byte0 0x01, byte47 0x41; digest = 0x01 then 31 x 0x00; 2 perm_start total; done once.
- msg_len 16, bytes 00..0F -> first perm_state_out bytes 0..15 = 00..0F, byte16 0x01, byte47 0x41; single absorb permutation.
- msg_len 17, bytes 00..10 -> first perm byte47 0x01 (cu 0); second Down xors 0x10 into byte0, 0x01 into byte1, byte47 ^= 0x40 only.
- out_len 5, hash_ready low 4 cycles on byte 2 -> hash_data stable, 5 bytes total, no second squeeze permutation, done after byte 5.
- reset asserted in WAIT_PERM, then perm_done -> IDLE, all outputs at reset values, no hash_valid.
- start pulsed during ABSORB with different msg_len -> ignored; original run completes unchanged.
